seq_det_event_logger: RTL

Downstream consumer of the serial sequence detector's one-bit detect output (y).
- Timestamps every detection with a free-running cycle counter.
- Buffers the timestamps in a small FIFO and presents them on a valid/ready read port.
- Keeps a saturating total event count and a sticky overflow flag for software or a later stage.

---
 rtl/seq_det_event_logger.sv | 117 +++++++++++
 1 files changed

// File: rtl/seq_det_event_logger.sv
// rtl/seq_det_event_logger.sv - timestamps sequence-detector hits into a show-ahead FIFO
//
// Purpose: every cycle where det_in and en are both high is an event. The
// event is stamped with a free-running cycle counter, queued in a small FIFO
// and offered on a valid/ready read port. A saturating event counter and a
// sticky overflow flag summarise activity for software.
//
// Ports:
//   clk        rising-edge system clock
//   rst        asynchronous active-low reset
//   det_in     detect pulse from the sequence detector (y)
//   en         logging enable; gates both the timestamp counter and events
//   clr        synchronous clear of evt_count and overflow
//   rd_ready   consumer accepts the head entry
//   rd_valid   FIFO non-empty
//   rd_data    timestamp at the FIFO head (show-ahead)
//   level      FIFO occupancy, 0..DEPTH
//   evt_count  saturating count of all events, including dropped ones
//   overflow   sticky: an event was dropped because the FIFO was full
module seq_det_event_logger #(
  parameter int TS_W  = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     det_in,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [TS_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         evt_count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [TS_W-1:0]  TS_ONE   = TS_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [TS_W-1:0]  ts;
  logic [TS_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  logic evt;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign evt      = det_in & en;
  assign full     = (level == LVL_FULL);
  assign rd_valid = (level != '0);
  assign rd_data  = mem[rptr];
  // A pop only happens on a non-empty FIFO, so an event into an empty FIFO
  // never bypasses straight to the read port.
  assign pop      = rd_valid & rd_ready;
  // When full, a same-cycle pop frees the slot the new entry lands in.
  assign push     = evt & (~full | pop);
  assign drop     = evt & full & ~pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts        <= '0;
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      evt_count <= '0;
      overflow  <= 1'b0;
      // Cleared so rd_data reads 0 immediately under reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (en) begin
        ts <= ts + TS_ONE;
      end

      if (push) begin
        mem[wptr] <= ts;
        wptr      <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end

      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase

      // clr restarts the count, but an event in the same cycle still counts.
      if (clr) begin
        evt_count <= evt ? CNT_ONE : '0;
      end else if (evt && (evt_count != CNT_MAX)) begin
        evt_count <= evt_count + CNT_ONE;
      end

      // A drop in the same cycle as clr keeps the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
